// File: rtl/mcdf_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : mcdf_arbiter_rr
// Brief    : MCDF channel arbiter. Priority plus fixed/round-robin tie-break,
//            grant locked for a whole packet, slave signals muxed to formatter.
// Revision : 1.0
// ============================================================================
module mcdf_arbiter_rr #(
    parameter int CH_NUM   = 4,
    parameter int DW       = 32,
    parameter int PRIO_W   = 2,
    parameter int PKGLEN_W = 3,
    parameter int ID_W     = $clog2(CH_NUM)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     arb_mode_i,
    input  logic [CH_NUM*PRIO_W-1:0] slv_prio_i,
    input  logic [CH_NUM*PKGLEN_W-1:0] slv_pkglen_i,
    input  logic [CH_NUM*DW-1:0]     slv_data_i,
    input  logic [CH_NUM-1:0]        slv_req_i,
    input  logic [CH_NUM-1:0]        slv_val_i,
    input  logic [CH_NUM-1:0]        slv_end_i,
    input  logic                     f2a_id_req_i,
    input  logic                     f2a_ack_i,
    output logic [CH_NUM-1:0]        a2s_ack_o,
    output logic                     a2f_val_o,
    output logic [DW-1:0]            a2f_data_o,
    output logic [PKGLEN_W-1:0]      a2f_pkglen_sel_o,
    output logic                     a2f_end_o,
    output logic [ID_W-1:0]          a2f_id_o,
    output logic                     a2f_id_val_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]          r_state;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_rr_ptr;

    logic [PRIO_W-1:0]   w_min_prio;
    logic [CH_NUM-1:0]   w_elig;
    logic [ID_W-1:0]     w_win_fixed;
    logic [ID_W-1:0]     w_win_rr;
    logic                w_found_fixed;
    logic                w_found_rr;
    logic [ID_W-1:0]     w_winner;
    logic                w_decide;
    logic                w_done;
    logic                w_lock;

    logic                w_val;
    logic                w_end;
    logic [DW-1:0]       w_data;
    logic [PKGLEN_W-1:0] w_pkglen;

    // Eligible set: requesting channels sharing the numerically smallest priority
    always_comb begin
        w_min_prio = '1;
        for (int k = 0; k < CH_NUM; k++) begin
            if (slv_req_i[k] && (slv_prio_i[k*PRIO_W +: PRIO_W] < w_min_prio)) begin
                w_min_prio = slv_prio_i[k*PRIO_W +: PRIO_W];
            end
        end
        w_elig = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            w_elig[k] = slv_req_i[k] && (slv_prio_i[k*PRIO_W +: PRIO_W] == w_min_prio);
        end
    end

    always_comb begin
        w_win_fixed   = '0;
        w_found_fixed = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (w_elig[k] && !w_found_fixed) begin
                w_win_fixed   = ID_W'(k);
                w_found_fixed = 1'b1;
            end
        end
        // Cyclic scan starting at the round-robin pointer
        w_win_rr   = '0;
        w_found_rr = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_elig[(int'(r_rr_ptr) + i) % CH_NUM] && !w_found_rr) begin
                w_win_rr   = ID_W'((int'(r_rr_ptr) + i) % CH_NUM);
                w_found_rr = 1'b1;
            end
        end
    end

    assign w_winner = arb_mode_i ? w_win_rr : w_win_fixed;
    assign w_lock   = (r_state == LOCK);
    assign w_decide = (r_state == IDLE) && f2a_id_req_i && (|slv_req_i);

    always_comb begin
        w_val    = 1'b0;
        w_end    = 1'b0;
        w_data   = '0;
        w_pkglen = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (ID_W'(k) == r_id) begin
                w_val    = slv_val_i[k];
                w_end    = slv_end_i[k];
                w_data   = slv_data_i[k*DW +: DW];
                w_pkglen = slv_pkglen_i[k*PKGLEN_W +: PKGLEN_W];
            end
        end
    end

    assign w_done = w_lock && f2a_ack_i && w_end && w_val;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= IDLE;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_decide) begin
                        r_state <= LOCK;
                        r_id    <= w_winner;
                    end
                end
                LOCK: begin
                    if (w_done) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= (r_id == ID_W'(CH_NUM - 1)) ? '0 : r_id + ID_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        a2s_ack_o = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (ID_W'(k) == r_id) begin
                a2s_ack_o[k] = w_lock && f2a_ack_i;
            end
        end
    end

    assign a2f_val_o        = w_lock && w_val;
    assign a2f_end_o        = w_lock && w_end;
    assign a2f_data_o       = w_lock ? w_data   : '0;
    assign a2f_pkglen_sel_o = w_lock ? w_pkglen : '0;
    assign a2f_id_o         = r_id;
    assign a2f_id_val_o     = w_lock;

endmodule
`default_nettype wire

// File: tb/tb_mcdf_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcdf_arbiter_rr
// Brief    : Directed self-checking bench for mcdf_arbiter_rr (CH_NUM=4).
// Revision : 1.0
// ============================================================================
module tb_mcdf_arbiter_rr;

    logic        clk;
    logic        rstn;
    logic        arb_mode;
    logic [7:0]  slv_prio;
    logic [11:0] slv_pkglen;
    logic [127:0] slv_data;
    logic [3:0]  slv_req;
    logic [3:0]  slv_val;
    logic [3:0]  slv_end;
    logic        id_req;
    logic        ack;
    logic [3:0]  a2s_ack;
    logic        a2f_val;
    logic [31:0] a2f_data;
    logic [2:0]  a2f_pkglen;
    logic        a2f_end;
    logic [1:0]  a2f_id;
    logic        a2f_id_val;

    int n_assert = 0;
    int n_fail   = 0;

    mcdf_arbiter_rr #(.CH_NUM(4), .DW(32), .PRIO_W(2), .PKGLEN_W(3)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .arb_mode_i       (arb_mode),
        .slv_prio_i       (slv_prio),
        .slv_pkglen_i     (slv_pkglen),
        .slv_data_i       (slv_data),
        .slv_req_i        (slv_req),
        .slv_val_i        (slv_val),
        .slv_end_i        (slv_end),
        .f2a_id_req_i     (id_req),
        .f2a_ack_i        (ack),
        .a2s_ack_o        (a2s_ack),
        .a2f_val_o        (a2f_val),
        .a2f_data_o       (a2f_data),
        .a2f_pkglen_sel_o (a2f_pkglen),
        .a2f_end_o        (a2f_end),
        .a2f_id_o         (a2f_id),
        .a2f_id_val_o     (a2f_id_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_idval"}, 32'(a2f_id_val), 32'd0);
        chk({tag, "_ack"},   32'(a2s_ack),    32'd0);
        chk({tag, "_val"},   32'(a2f_val),    32'd0);
        chk({tag, "_data"},  a2f_data,        32'd0);
    endtask

    initial begin
        rstn       = 1'b0;
        arb_mode   = 1'b0;
        slv_prio   = 8'h00;
        slv_pkglen = {3'd7, 3'd6, 3'd5, 3'd4};
        slv_data   = {32'hD3D3_0003, 32'hC2C2_0002, 32'hA5A5_0001, 32'hB0B0_0000};
        slv_req    = 4'b0000;
        slv_val    = 4'b0000;
        slv_end    = 4'b0000;
        id_req     = 1'b0;
        ack        = 1'b0;

        // Reset and idle with no requests
        tick(); tick();
        chk_quiet("rst");
        chk("rst_id", 32'(a2f_id), 32'd0);
        rstn   = 1'b1;
        id_req = 1'b1;
        tick(); tick();
        chk_quiet("idle_noreq");

        // Fixed priority: ch1 and ch3 share prio 0, lowest index wins
        slv_prio = {2'd0, 2'd1, 2'd0, 2'd2};
        slv_req  = 4'b1111;
        slv_val  = 4'b1111;
        slv_end  = 4'b1111;
        tick();
        id_req = 1'b0;
        chk("fix_id",    32'(a2f_id),     32'd1);
        chk("fix_idval", 32'(a2f_id_val), 32'd1);
        ack = 1'b1;
        #1;
        chk("fix_ack", 32'(a2s_ack), 32'b0010);
        tick();
        ack = 1'b0;
        chk("fix_done_idval", 32'(a2f_id_val), 32'd0);
        chk("fix_done_id",    32'(a2f_id),     32'd1);
        id_req = 1'b1;
        tick();
        id_req = 1'b0;
        chk("fix_id2", 32'(a2f_id), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Ack routing and mux: only ch1 requesting
        slv_prio = 8'h00;
        slv_req  = 4'b0010;
        slv_val  = 4'b0010;
        slv_end  = 4'b0000;
        id_req   = 1'b1;
        tick();
        id_req = 1'b0;
        ack    = 1'b1;
        #1;
        chk("mux_id",     32'(a2f_id),     32'd1);
        chk("mux_data",   a2f_data,        32'hA5A5_0001);
        chk("mux_ack",    32'(a2s_ack),    32'b0010);
        chk("mux_pkglen", 32'(a2f_pkglen), 32'd5);
        chk("mux_end",    32'(a2f_end),    32'd0);
        tick();
        chk("mux_hold", 32'(a2f_id_val), 32'd1);
        slv_end = 4'b0010;
        tick();
        ack = 1'b0;
        #1;
        chk_quiet("mux_after");

        // Packet lock: grant ch2, disturb mid-packet, 4 beats
        slv_req = 4'b0100;
        slv_val = 4'b0100;
        slv_end = 4'b0000;
        id_req  = 1'b1;
        tick();
        id_req = 1'b0;
        chk("lock_id", 32'(a2f_id), 32'd2);
        ack = 1'b1;
        #1;
        chk("lock_b1_ack", 32'(a2s_ack), 32'b0100);
        tick();
        slv_req  = 4'b1111;
        slv_prio = {2'd3, 2'd3, 2'd3, 2'd0};
        arb_mode = 1'b1;
        id_req   = 1'b1;
        ack      = 1'b0;
        #1;
        chk("lock_noack", 32'(a2s_ack), 32'b0000);
        tick();
        chk("lock_id_held", 32'(a2f_id),     32'd2);
        chk("lock_idval",   32'(a2f_id_val), 32'd1);
        slv_req = 4'b0000;
        ack     = 1'b1;
        tick();
        tick();
        chk("lock_id_b3", 32'(a2f_id), 32'd2);
        slv_req = 4'b1111;
        slv_end = 4'b0100;
        #1;
        chk("lock_end_ack", 32'(a2s_ack), 32'b0100);
        chk("lock_end",     32'(a2f_end), 32'd1);
        tick();
        ack = 1'b0;
        chk("lock_done_idval", 32'(a2f_id_val), 32'd0);
        chk("lock_done_id",    32'(a2f_id),     32'd2);
        id_req = 1'b0;

        // Reset mid-packet: round-robin pointer is 3 here, grant ch3
        slv_prio = 8'h00;
        slv_val  = 4'b1111;
        slv_end  = 4'b0000;
        id_req   = 1'b1;
        tick();
        id_req = 1'b0;
        chk("rr3_id", 32'(a2f_id), 32'd3);
        ack = 1'b1;
        tick();
        #1;
        chk("pre_rst_data", a2f_data, 32'hD3D3_0003);
        rstn = 1'b0;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_id", 32'(a2f_id), 32'd0);
        ack = 1'b0;
        tick();
        rstn    = 1'b1;
        slv_end = 4'b1111;
        tick();

        // Round-robin from ch0 with one-beat packets
        for (int p = 0; p < 5; p++) begin
            id_req = 1'b1;
            tick();
            id_req = 1'b0;
            chk($sformatf("rr_seq%0d", p), 32'(a2f_id), 32'(p % 4));
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
